spi_window_sequencer: RTL and testbench
=======================================

Name: spi_window_sequencer

Overview:
- Multi-channel, parametrised successor to the single-window SPI clock-count sequencer.
- Counts SPI_Clk falling edges while SPI_CS is low. From the count it generates:
  - a programmable active-low ring-oscillator counter reset pulse (ROCNT_Rst);
  - N_CH independent enable windows (ENOUT) that gate the RO counters.
- Sits between the SPI slave front end and the RO counter bank of the VT sensor.

Parameters:
- CNT_W, 8: width of the SPI clock counter and of all count-compare fields.
- N_CH, 4: number of enable channels.

Ports:
- SPI_Clk  in  1: single clock; all state updates on its falling edge.
- RSTLOW  in  1: synchronous, active-low reset, sampled on SPI_Clk falling edge.
- SPI_CS  in  1: SPI chip select, active low; a measurement session runs while low.
- Rst_Start  in  CNT_W: count at which ROCNT_Rst asserts (goes low).
- Rst_Len  in  CNT_W: number of counts ROCNT_Rst stays low; 0 means no reset pulse.
- En_Start  in  N_CH*CNT_W: per-channel enable start count; channel i is at bits [i*CNT_W +: CNT_W].
- En_End  in  N_CH*CNT_W: per-channel enable end count (exclusive).
- Ch_Mask  in  N_CH: per-channel enable mask; 0 keeps that ENOUT low.
- ENOUT  out  N_CH: per-channel RO enable, registered.
- ROCNT_Rst  out  1: RO counter reset, active low, registered.
- Busy  out  1: high while in RUN.
- Overflow  out  1: sticky; counter saturated during the current session.
- Cfg_Err  out  N_CH: per-channel sticky flag, set when En_End <= En_Start.

Behaviour:
- Reset (RSTLOW=0 at a falling edge):
  - state IDLE, cnt=0;
  - ROCNT_Rst=1 (RO counter retains its value), ENOUT=0, Busy=0, Overflow=0, Cfg_Err=0.
- Reset has priority over every other event. Reset mid-session aborts the session immediately.
- State machine has three states: IDLE, RUN, SAT.
- IDLE:
  - ROCNT_Rst=1, ENOUT=0, cnt=0.
  - On the first falling edge with SPI_CS=0:
    - latch all config inputs (Rst_Start, Rst_Len, En_Start, En_End, Ch_Mask) into shadow registers;
    - cnt becomes 1, go to RUN, clear Overflow;
    - update Cfg_Err from the latched values;
    - outputs for count 1 are produced on this same edge.
  - Config input changes during RUN have no effect until the next session.
- RUN: each falling edge with SPI_CS=0 computes nxt=cnt+1. All outputs are registered from nxt, so the output at edge k reflects count k:
  - ROCNT_Rst = 0 iff Rst_Len!=0 and Rst_Start <= nxt < Rst_Start+Rst_Len. The sum is evaluated in CNT_W+1 bits, with no wrap.
  - ENOUT[i] = 1 iff Ch_Mask[i], En_Start[i] <= nxt < En_End[i], and ROCNT_Rst (the value being registered) = 1. Reset overrides enable.
  - When nxt reaches 2^CNT_W-1: set Overflow, go to SAT.
- SAT:
  - cnt holds at 2^CNT_W-1; ENOUT=0; ROCNT_Rst=1.
  - No further windows are generated until the session ends.
- Session end: any falling edge with SPI_CS=1 in RUN or SAT:
  - next state IDLE, cnt=0, ENOUT=0, ROCNT_Rst=1;
  - Overflow and Cfg_Err hold their values until the next session start.
- Cfg_Err[i]: set at session start when En_End[i] <= En_Start[i]. That channel stays low for the whole session.
- Counts equal to 0 never occur in RUN:
  - Rst_Start=0 behaves as Rst_Start=1 with length reduced by one;
  - En_Start=0 behaves as En_Start=1.
- SPI_CS low for a single edge: one RUN cycle with count 1, then IDLE.
- Latency: one falling edge from count change to output change. No combinational input-to-output paths.

Test Plan:
- Reset checks:
  - RSTLOW=0 for 3 edges with SPI_CS=0 -> ROCNT_Rst=1, ENOUT=0, Busy=0, Overflow=0, Cfg_Err=0, and no counting.
  - Release RSTLOW -> counting starts at the next edge.
- Basic window: Rst_Start=1, Rst_Len=1, En_Start[0]=3, En_End[0]=20, Ch_Mask=0001, 30 edges with CS low ->
  - ROCNT_Rst low exactly at edge 1;
  - ENOUT[0] high for edges 3 to 19 (17 edges);
  - ENOUT[3:1]=0.
- Multi-channel with overlap: windows ch0 [3,10), ch1 [5,6), ch2 [8,8), ch3 [2,12) with Rst_Start=2, Rst_Len=3 ->
  - ENOUT[3] low for counts 2-4 (reset override), high 5-11;
  - ch1 high only at count 5;
  - Cfg_Err=0100.
- Overflow: CNT_W=8, hold CS low 300 edges ->
  - Overflow=1 and state SAT at edge 255;
  - cnt holds at 255, ENOUT=0.
  - Raise CS -> IDLE, Overflow stays 1 until the next CS-low edge clears it.
- Abort mid-session: CS high at edge 7, inside an En [3,20) window ->
  - ENOUT=0 and ROCNT_Rst=1 at edge 7;
  - next session restarts at count 1 with newly latched config.
- Mid-session reset: RSTLOW=0 at edge 5 with ENOUT[0]=1 ->
  - all outputs return to reset values at that edge;
  - after release with CS still low, a fresh session starts at count 1.

Source files
------------

// File: rtl/spi_window_sequencer.sv
// SPI clock-count sequencer: counts SPI_Clk falling edges during a chip-select session and
// derives an active-low RO counter reset pulse plus N_CH independently gated enable windows.
module spi_window_sequencer #(
  parameter int CNT_W = 8,
  parameter int N_CH  = 4
) (
  input  logic                  SPI_Clk,
  input  logic                  RSTLOW,
  input  logic                  SPI_CS,
  input  logic [CNT_W-1:0]      Rst_Start,
  input  logic [CNT_W-1:0]      Rst_Len,
  input  logic [N_CH*CNT_W-1:0] En_Start,
  input  logic [N_CH*CNT_W-1:0] En_End,
  input  logic [N_CH-1:0]       Ch_Mask,
  output logic [N_CH-1:0]       ENOUT,
  output logic                  ROCNT_Rst,
  output logic                  Busy,
  output logic                  Overflow,
  output logic [N_CH-1:0]       Cfg_Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_rst_start;
  logic [CNT_W-1:0]      r_rst_len;
  logic [N_CH*CNT_W-1:0] r_en_start;
  logic [N_CH*CNT_W-1:0] r_en_end;
  logic [N_CH-1:0]       r_ch_mask;
  logic [N_CH-1:0]       r_enout;
  logic                  r_rocnt_rst;
  logic                  r_overflow;
  logic [N_CH-1:0]       r_cfg_err;

  state_t                w_state_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [N_CH-1:0]       w_enout_next;
  logic                  w_rocnt_next;
  logic                  w_overflow_next;
  logic [N_CH-1:0]       w_cfg_err_next;
  logic                  w_advance;

  logic                  w_start;
  logic [CNT_W-1:0]      w_rst_start;
  logic [CNT_W-1:0]      w_rst_len;
  logic [N_CH*CNT_W-1:0] w_en_start;
  logic [N_CH*CNT_W-1:0] w_en_end;
  logic [N_CH-1:0]       w_ch_mask;
  logic [CNT_W-1:0]      w_nxt;
  logic [CNT_W:0]        w_rst_end;
  logic                  w_rst_win;
  logic [N_CH-1:0]       w_cfg_bad;
  logic [N_CH-1:0]       w_en_win;

  // On the session-start edge the shadows are still loading, so windows use the live inputs.
  assign w_start     = (r_state == S_IDLE) && !SPI_CS;
  assign w_rst_start = w_start ? Rst_Start : r_rst_start;
  assign w_rst_len   = w_start ? Rst_Len   : r_rst_len;
  assign w_en_start  = w_start ? En_Start  : r_en_start;
  assign w_en_end    = w_start ? En_End    : r_en_end;
  assign w_ch_mask   = w_start ? Ch_Mask   : r_ch_mask;
  assign w_nxt       = w_start ? CNT_ONE   : r_cnt + CNT_ONE;

  assign w_rst_end = {1'b0, w_rst_start} + {1'b0, w_rst_len};
  assign w_rst_win = (w_rst_len != '0) && (w_nxt >= w_rst_start) &&
                     ({1'b0, w_nxt} < w_rst_end);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] w_es;
    logic [CNT_W-1:0] w_ee;
    assign w_es          = w_en_start[gi*CNT_W +: CNT_W];
    assign w_ee          = w_en_end[gi*CNT_W +: CNT_W];
    assign w_cfg_bad[gi] = (w_ee <= w_es);
    assign w_en_win[gi]  = w_ch_mask[gi] && !w_cfg_bad[gi] &&
                           (w_nxt >= w_es) && (w_nxt < w_ee);
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_enout_next    = '0;
    w_rocnt_next    = 1'b1;
    w_overflow_next = r_overflow;
    w_cfg_err_next  = r_cfg_err;
    w_advance       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!SPI_CS) begin
          w_advance       = 1'b1;
          w_overflow_next = 1'b0;
          w_cfg_err_next  = w_cfg_bad;
        end
      end
      S_RUN: begin
        if (SPI_CS) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_SAT: begin
        if (SPI_CS) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    // Reaching full scale ends window generation for the rest of the session.
    if (w_advance) begin
      w_cnt_next = w_nxt;
      if (w_nxt == CNT_MAX) begin
        w_state_next    = S_SAT;
        w_overflow_next = 1'b1;
      end else begin
        w_state_next = S_RUN;
        w_rocnt_next = ~w_rst_win;
        w_enout_next = w_rst_win ? '0 : w_en_win;
      end
    end
  end

  always_ff @(negedge SPI_Clk) begin
    if (!RSTLOW) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rst_start <= '0;
      r_rst_len   <= '0;
      r_en_start  <= '0;
      r_en_end    <= '0;
      r_ch_mask   <= '0;
      r_enout     <= '0;
      r_rocnt_rst <= 1'b1;
      r_overflow  <= 1'b0;
      r_cfg_err   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_enout     <= w_enout_next;
      r_rocnt_rst <= w_rocnt_next;
      r_overflow  <= w_overflow_next;
      r_cfg_err   <= w_cfg_err_next;
      if (w_start) begin
        r_rst_start <= Rst_Start;
        r_rst_len   <= Rst_Len;
        r_en_start  <= En_Start;
        r_en_end    <= En_End;
        r_ch_mask   <= Ch_Mask;
      end
    end
  end

  assign ENOUT     = r_enout;
  assign ROCNT_Rst = r_rocnt_rst;
  assign Busy      = (r_state == S_RUN);
  assign Overflow  = r_overflow;
  assign Cfg_Err   = r_cfg_err;

endmodule

// File: tb/tb_spi_window_sequencer.sv
// Scoreboard bench for spi_window_sequencer: a count-based reference predicts each falling edge,
// predictions are queued when stimulus is driven and compared after the edge.
`timescale 1ns/1ps
module tb_spi_window_sequencer;
  localparam int CNT_W = 8;
  localparam int N_CH  = 4;

  logic                  SPI_Clk;
  logic                  RSTLOW;
  logic                  SPI_CS;
  logic [CNT_W-1:0]      Rst_Start;
  logic [CNT_W-1:0]      Rst_Len;
  logic [N_CH*CNT_W-1:0] En_Start;
  logic [N_CH*CNT_W-1:0] En_End;
  logic [N_CH-1:0]       Ch_Mask;
  logic [N_CH-1:0]       ENOUT;
  logic                  ROCNT_Rst;
  logic                  Busy;
  logic                  Overflow;
  logic [N_CH-1:0]       Cfg_Err;

  spi_window_sequencer #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
    .SPI_Clk  (SPI_Clk),
    .RSTLOW   (RSTLOW),
    .SPI_CS   (SPI_CS),
    .Rst_Start(Rst_Start),
    .Rst_Len  (Rst_Len),
    .En_Start (En_Start),
    .En_End   (En_End),
    .Ch_Mask  (Ch_Mask),
    .ENOUT    (ENOUT),
    .ROCNT_Rst(ROCNT_Rst),
    .Busy     (Busy),
    .Overflow (Overflow),
    .Cfg_Err  (Cfg_Err)
  );

  initial SPI_Clk = 1'b0;
  always #5 SPI_Clk = ~SPI_Clk;

  typedef struct packed {
    logic [3:0] cfg;
    logic       ovf;
    logic       busy;
    logic       rst;
    logic [3:0] en;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t last_o;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;

  // reference model state: 0 idle, 1 run, 2 saturated
  int         m_state = 0;
  int         m_cnt   = 0;
  int         m_rs    = 0;
  int         m_rl    = 0;
  int         m_es[N_CH];
  int         m_ee[N_CH];
  logic [3:0] m_mask  = '0;
  logic [3:0] m_cfg   = '0;
  logic       m_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(output obs_t e);
    logic       rst_low;
    logic [3:0] en;
    rst_low = 1'b0;
    en      = '0;
    if (!RSTLOW) begin
      m_state = 0; m_cnt = 0; m_ovf = 1'b0; m_cfg = '0;
    end else if (SPI_CS) begin
      m_state = 0; m_cnt = 0;
    end else begin
      if (m_state == 0) begin
        m_rs = int'(Rst_Start); m_rl = int'(Rst_Len); m_mask = Ch_Mask; m_ovf = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          m_es[i]  = int'(En_Start[i*CNT_W +: CNT_W]);
          m_ee[i]  = int'(En_End[i*CNT_W +: CNT_W]);
          m_cfg[i] = (m_ee[i] <= m_es[i]);
        end
        m_cnt = 1; m_state = 1;
      end else if (m_state == 1) begin
        m_cnt++;
      end
      if (m_state == 1) begin
        if (m_cnt == 255) begin
          m_state = 2; m_ovf = 1'b1;
        end else begin
          rst_low = (m_rl != 0) && (m_cnt >= m_rs) && (m_cnt < m_rs + m_rl);
          for (int i = 0; i < N_CH; i++)
            en[i] = m_mask[i] && (m_cnt >= m_es[i]) && (m_cnt < m_ee[i]) && !rst_low;
        end
      end
    end
    e.cfg  = m_cfg;
    e.ovf  = m_ovf;
    e.busy = (m_state == 1);
    e.rst  = !rst_low;
    e.en   = en;
    e.cnt  = 8'(m_cnt);
  endtask

  task automatic tick(input logic cs, input logic rstn);
    obs_t e;
    @(posedge SPI_Clk);
    SPI_CS = cs;
    RSTLOW = rstn;
    model_edge(e);
    exp_q.push_back(e);
    @(negedge SPI_Clk);
    #2;
    edge_no++;
    last_o = {Cfg_Err, Overflow, Busy, ROCNT_Rst, ENOUT, dut.r_cnt};
    e = exp_q.pop_front();
    check_val($sformatf("edge%0d", edge_no), 32'(last_o), 32'(e));
    $display("edge %0d cs=%b rstn=%b cnt=%0d en=%b rocnt=%b busy=%b ovf=%b cfg=%b",
             edge_no, cs, rstn, last_o.cnt, last_o.en, last_o.rst, last_o.busy,
             last_o.ovf, last_o.cfg);
  endtask

  task automatic set_cfg(input logic [7:0] rs, input logic [7:0] rl, input logic [31:0] es,
                         input logic [31:0] ee, input logic [3:0] mask);
    Rst_Start = rs; Rst_Len = rl; En_Start = es; En_End = ee; Ch_Mask = mask;
  endtask

  int en0_hi;
  int rst_lo;
  int ch1_hi;
  logic [3:0] upper;

  initial begin
    RSTLOW = 1'b0;
    SPI_CS = 1'b0;
    set_cfg(8'd1, 8'd1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd20}, 4'b0001);

    // reset held with CS low: nothing counts
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check_val("reset_outputs", 32'({Cfg_Err, Overflow, Busy, ROCNT_Rst, ENOUT}), 32'(11'b0000_0_0_1_0000));

    // basic window, counting starts at the first released edge
    en0_hi = 0; rst_lo = 0; upper = '0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b1);
      en0_hi += int'(last_o.en[0]);
      rst_lo += int'(!last_o.rst);
      upper  |= {1'b0, last_o.en[3:1]};
    end
    check_val("basic_en0_len", 32'(en0_hi), 32'd17);
    check_val("basic_rst_len", 32'(rst_lo), 32'd1);
    check_val("basic_en_upper", 32'(upper), 32'd0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    // overlapping channels, reset override, one bad window
    set_cfg(8'd2, 8'd3, {8'd2, 8'd8, 8'd5, 8'd3}, {8'd12, 8'd8, 8'd6, 8'd10}, 4'b1111);
    ch1_hi = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1);
      ch1_hi += int'(last_o.en[1]);
    end
    check_val("multi_ch1_len", 32'(ch1_hi), 32'd1);
    check_val("multi_cfg_err", 32'(Cfg_Err), 32'b0100);
    tick(1'b1, 1'b1);

    // saturation
    set_cfg(8'd1, 8'd1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd20}, 4'b0001);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1);
    check_val("sat_cnt", 32'(dut.r_cnt), 32'd255);
    check_val("sat_ovf", 32'(Overflow), 32'd1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_val("ovf_sticky_idle", 32'(Overflow), 32'd1);
    tick(1'b0, 1'b1);
    check_val("ovf_cleared", 32'(Overflow), 32'd0);
    tick(1'b1, 1'b1);

    // abort at edge 7; config changes mid-session are ignored until the next session
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      if (i == 2)
        set_cfg(8'd0, 8'd2, {8'd0, 8'd0, 8'd1, 8'd2}, {8'd0, 8'd0, 8'd3, 8'd4}, 4'b0011);
    end
    check_val("abort_pre_en0", 32'(ENOUT[0]), 32'd1);
    tick(1'b1, 1'b1);
    check_val("abort_en", 32'(ENOUT), 32'd0);
    check_val("abort_rocnt", 32'(ROCNT_Rst), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);

    // reset during an open window, then a fresh session with CS still low
    set_cfg(8'd1, 8'd1, {8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd20}, 4'b0001);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check_val("midrst_pre_en0", 32'(ENOUT[0]), 32'd1);
    tick(1'b0, 1'b0);
    check_val("midrst_outputs", 32'({Cfg_Err, Overflow, Busy, ROCNT_Rst, ENOUT}), 32'(11'b0000_0_0_1_0000));
    tick(1'b0, 1'b1);
    check_val("midrst_restart_cnt", 32'(dut.r_cnt), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);

    // a few random sessions
    for (int s = 0; s < 4; s++) begin
      set_cfg(8'($urandom_range(0, 10)), 8'($urandom_range(0, 6)),
              {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)),
               8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))},
              {8'($urandom_range(0, 30)), 8'($urandom_range(0, 30)),
               8'($urandom_range(0, 30)), 8'($urandom_range(0, 30))},
              4'($urandom_range(0, 15)));
      for (int i = 0; i < int'($urandom_range(3, 40)); i++) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
